// File: rtl/ica_pkg.sv
// Shared types and helpers for the ICA weight-update engine.
// Holds the saturation function, the default identity constant and the element-index type.
package ica_pkg;

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned SAT_W  = 128;

    localparam logic [63:0] ICA_IDENT_DEFAULT = 64'd2305843009000000000;

    typedef logic [IDX_W-1:0] elem_idx_t;

    // Clamp a signed value to the range of a signed number of the given width.
    // The result stays SAT_W wide; callers take the low bits they need.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = {SAT_W{1'b1}} >> (SAT_W - width + 1);
        min_v = ~max_v;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/ica_weight_update_lane.sv
// Three-stage update pipeline for one matrix element: d, product, then shift/saturate/sum.
// The third stage is combinational here; the caller registers its result into the weight file.
module ica_update_lane
    import ica_pkg::*;
#(
    parameter int unsigned    HW        = 64,
    parameter int unsigned    WW        = 16,
    parameter int unsigned    SLICE_LSB = 47,
    parameter logic [HW-1:0]  IDENT     = HW'(ICA_IDENT_DEFAULT),
    parameter int unsigned    CONV_TH   = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  elem_idx_t     idx_i,
    input  logic [HW-1:0] h_i,
    input  logic [HW-1:0] p_i,
    input  logic [WW-1:0] w_i,
    output logic          valid_o,
    output elem_idx_t     idx_o,
    output logic [WW-1:0] sum_o,
    output logic          sat_o,
    output logic          conv_o
);

    localparam int unsigned DW = HW + 2;
    localparam int unsigned MW = HW + WW + 2;

    logic                 s1_valid_q, s1_valid_d;
    elem_idx_t            s1_idx_q, s1_idx_d;
    logic signed [DW-1:0] d_q, d_d;
    logic signed [WW-1:0] s1_w_q, s1_w_d;

    logic                 s2_valid_q, s2_valid_d;
    elem_idx_t            s2_idx_q, s2_idx_d;
    logic signed [MW-1:0] m_q, m_d;
    logic signed [WW-1:0] s2_w_q, s2_w_d;

    logic signed [MW-1:0]    shifted;
    logic signed [SAT_W-1:0] delta_ext;
    logic signed [SAT_W-1:0] delta_full;
    logic        [WW-1:0]    delta;
    logic                    delta_sat;
    logic        [WW:0]      sum_raw;
    logic signed [SAT_W-1:0] sum_ext;
    logic signed [SAT_W-1:0] sum_full;
    logic                    sum_sat;
    logic        [WW:0]      delta_x;
    logic        [WW:0]      abs_delta;

    // Stage 1: two extra bits make IDENT - h - p exact for any 64-bit inputs.
    always_comb begin
        s1_valid_d = valid_i;
        s1_idx_d   = idx_i;
        s1_w_d     = w_i;
        d_d        = {{2{IDENT[HW-1]}}, IDENT} - {{2{h_i[HW-1]}}, h_i}
                     - {{2{p_i[HW-1]}}, p_i};
    end

    // Stage 2: operands sign-extended to the full product width, so the low MW bits are exact.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_idx_d   = s1_idx_q;
        s2_w_d     = s1_w_q;
        m_d        = {{(MW-DW){d_q[DW-1]}}, d_q} * {{(MW-WW){s1_w_q[WW-1]}}, s1_w_q};
    end

    // Stage 3: floor shift, clamp delta, add to w, clamp sum.
    always_comb begin
        shifted    = m_q >>> SLICE_LSB;
        delta_ext  = {{(SAT_W-MW){shifted[MW-1]}}, shifted};
        delta_full = sat_signed(delta_ext, WW);
        delta      = delta_full[WW-1:0];
        delta_sat  = (delta_full != delta_ext);

        sum_raw    = {s2_w_q[WW-1], s2_w_q} + {delta[WW-1], delta};
        sum_ext    = {{(SAT_W-WW-1){sum_raw[WW]}}, sum_raw};
        sum_full   = sat_signed(sum_ext, WW);
        sum_sat    = (sum_full != sum_ext);

        // The most negative delta becomes 2^(WW-1) here, always above the threshold.
        delta_x    = {delta[WW-1], delta};
        abs_delta  = delta[WW-1] ? (~delta_x + (WW+1)'(1)) : delta_x;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            d_q        <= '0;
            s1_w_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            m_q        <= '0;
            s2_w_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            d_q        <= d_d;
            s1_w_q     <= s1_w_d;
            s2_valid_q <= s2_valid_d;
            s2_idx_q   <= s2_idx_d;
            m_q        <= m_d;
            s2_w_q     <= s2_w_d;
        end
    end

    assign valid_o = s2_valid_q;
    assign idx_o   = s2_idx_q;
    assign sum_o   = sum_full[WW-1:0];
    assign sat_o   = delta_sat | sum_sat;
    assign conv_o  = (abs_delta <= (WW+1)'(CONV_TH));

endmodule

// File: rtl/ica_weight_update.sv
// ICA weight-update engine: streams N*N elements through one update lane and collects
// the results into the winit register file, with start/busy/done handshake and sat/conv flags.
module ica_weight_update
    import ica_pkg::*;
#(
    parameter int unsigned    N         = 3,
    parameter int unsigned    HW        = 64,
    parameter int unsigned    WW        = 16,
    parameter int unsigned    SLICE_LSB = 47,
    parameter logic [HW-1:0]  IDENT     = HW'(ICA_IDENT_DEFAULT),
    parameter int unsigned    CONV_TH   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*N*HW-1:0] h_in,
    input  logic [N*N*HW-1:0] p_in,
    input  logic [N*N*WW-1:0] w_in,
    output logic              busy,
    output logic              done,
    output logic [N*N*WW-1:0] winit_out,
    output logic              sat,
    output logic              conv
);

    localparam int unsigned NE = N * N;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]       state_q, state_d;
    elem_idx_t        idx_q, idx_d;
    logic             done_q, done_d;
    logic             sat_q, sat_d;
    logic             conv_q, conv_d;
    logic             conv_acc_q, conv_acc_d;
    logic [NE*WW-1:0] winit_q, winit_d;

    logic             issue_valid;
    logic [HW-1:0]    h_sel;
    logic [HW-1:0]    p_sel;
    logic [WW-1:0]    w_sel;

    logic             lane_valid;
    elem_idx_t        lane_idx;
    logic [WW-1:0]    lane_sum;
    logic             lane_sat;
    logic             lane_conv;

    // Input mux: select element idx_q from the flattened matrices.
    always_comb begin
        h_sel = '0;
        p_sel = '0;
        w_sel = '0;
        for (int k = 0; k < NE; k++) begin
            if (idx_q == elem_idx_t'(k)) begin
                h_sel = h_in[k*HW +: HW];
                p_sel = p_in[k*HW +: HW];
                w_sel = w_in[k*WW +: WW];
            end
        end
    end

    ica_update_lane #(
        .HW        (HW),
        .WW        (WW),
        .SLICE_LSB (SLICE_LSB),
        .IDENT     (IDENT),
        .CONV_TH   (CONV_TH)
    ) u_lane (
        .clk_i   (clk),
        .rst_ni  (rst),
        .valid_i (issue_valid),
        .idx_i   (idx_q),
        .h_i     (h_sel),
        .p_i     (p_sel),
        .w_i     (w_sel),
        .valid_o (lane_valid),
        .idx_o   (lane_idx),
        .sum_o   (lane_sum),
        .sat_o   (lane_sat),
        .conv_o  (lane_conv)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        sat_d       = sat_q;
        conv_d      = conv_q;
        conv_acc_d  = conv_acc_q;
        winit_d     = winit_q;
        issue_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = '0;
                    sat_d      = 1'b0;
                    conv_d     = 1'b0;
                    conv_acc_d = 1'b1;
                end
            end
            StRun: begin
                issue_valid = 1'b1;
                if (idx_q == elem_idx_t'(NE - 1)) begin
                    state_d = StDrain;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + elem_idx_t'(1);
                end
            end
            StDrain: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The drain phase ends when the last element leaves the lane.
        if (lane_valid) begin
            for (int k = 0; k < NE; k++) begin
                if (lane_idx == elem_idx_t'(k)) begin
                    winit_d[k*WW +: WW] = lane_sum;
                end
            end
            sat_d      = sat_q | lane_sat;
            conv_acc_d = conv_acc_q & lane_conv;
            if (lane_idx == elem_idx_t'(NE - 1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
                conv_d  = conv_acc_q & lane_conv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            conv_q     <= 1'b0;
            conv_acc_q <= 1'b0;
            winit_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
            conv_q     <= conv_d;
            conv_acc_q <= conv_acc_d;
            winit_q    <= winit_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign winit_out = winit_q;
    assign sat       = sat_q;
    assign conv      = conv_q;

endmodule
